// File: rtl/sprite_dma.sv
// sprite_dma: copies the sprite attribute table from CPU work RAM into sprite RAM, one byte per clock.
module sprite_dma #(
  parameter int LENGTH    = 128,
  parameter int DST_WIDTH = 7,
  parameter int SRC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank,
  input  logic                 cpu_reg_wr,
  input  logic [1:0]           cpu_reg_addr,
  input  logic [7:0]           cpu_reg_din,
  output logic [7:0]           cpu_reg_dout,
  output logic [SRC_WIDTH-1:0] src_addr,
  input  logic [7:0]           src_data,
  output logic                 spriteram_wr,
  output logic [DST_WIDTH-1:0] spriteram_wr_addr,
  output logic [7:0]           spriteram_data_in,
  output logic                 dma_busy,
  output logic                 dma_done
);
  localparam int IW = $clog2(LENGTH) + 1;
  typedef enum logic [2:0] {IDLE, ARMED, COPY, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] src_base_q, src_base_d;
  logic [SRC_WIDTH-1:0] cur_src_q, cur_src_d, src_addr_q, src_addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic vblank_last_q;
  logic ctrl_start;
  assign ctrl_start = cpu_reg_wr && cpu_reg_addr == 2'd2 && cpu_reg_din[0];
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    idx_d      = idx_q;
    src_addr_d = src_addr_q;
    src_base_d = !cpu_reg_wr ? src_base_q :
                 cpu_reg_addr == 2'd0 ? {src_base_q[15:8], cpu_reg_din} :
                 cpu_reg_addr == 2'd1 ? {cpu_reg_din, src_base_q[7:0]} : src_base_q;
    case (state_q)
      IDLE: if (ctrl_start) begin
        state_d   = cpu_reg_din[1] ? COPY : ARMED;
        cur_src_d = src_base_q[SRC_WIDTH-1:0];
        idx_d     = '0;
        if (cpu_reg_din[1]) src_addr_d = src_base_q[SRC_WIDTH-1:0];
      end
      ARMED: if (vblank && !vblank_last_q) begin
        state_d    = COPY;
        src_addr_d = cur_src_q;
      end
      COPY: begin
        // Writes lag reads by one clock (sync RAM), so idx keeps counting into FLUSH.
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(LENGTH - 1)) state_d = FLUSH;
        else src_addr_d = cur_src_q + SRC_WIDTH'(idx_d);
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      src_base_q    <= '0;
      cur_src_q     <= '0;
      idx_q         <= '0;
      src_addr_q    <= '0;
      vblank_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_base_q    <= src_base_d;
      cur_src_q     <= cur_src_d;
      idx_q         <= idx_d;
      src_addr_q    <= src_addr_d;
      vblank_last_q <= vblank;
    end
  end
  assign dma_busy          = state_q == ARMED || state_q == COPY;
  assign dma_done          = state_q == DONE;
  assign cpu_reg_dout      = {6'b0, state_q == ARMED, dma_busy};
  assign src_addr          = src_addr_q;
  assign spriteram_wr      = (state_q == COPY && idx_q != '0) || state_q == FLUSH;
  assign spriteram_wr_addr = spriteram_wr ? DST_WIDTH'(idx_q - 1'b1) : '0;
  assign spriteram_data_in = spriteram_wr ? src_data : 8'h00;
endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: directed scenarios for sprite_dma with a work RAM model and a sprite RAM capture.
module tb_sprite_dma;
  logic clk = 1'b0;
  logic reset, vblank, cpu_reg_wr;
  logic [1:0] cpu_reg_addr;
  logic [7:0] cpu_reg_din, cpu_reg_dout, src_data, spriteram_data_in;
  logic [15:0] src_addr;
  logic spriteram_wr, dma_busy, dma_done;
  logic [6:0] spriteram_wr_addr, last_addr;
  logic [7:0] mem [0:65535];
  logic [7:0] spr [0:127];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, order_err = 0, start_wr_cyc = -1, done_cyc = -1;
  sprite_dma dut (
    .clk(clk), .reset(reset), .vblank(vblank), .cpu_reg_wr(cpu_reg_wr),
    .cpu_reg_addr(cpu_reg_addr), .cpu_reg_din(cpu_reg_din), .cpu_reg_dout(cpu_reg_dout),
    .src_addr(src_addr), .src_data(src_data), .spriteram_wr(spriteram_wr),
    .spriteram_wr_addr(spriteram_wr_addr), .spriteram_data_in(spriteram_data_in),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    src_data <= mem[src_addr];
  end
  // cyc+1 is the edge at which the sampled write/done commits
  always @(negedge clk) begin
    if (spriteram_wr) begin
      if (spriteram_wr_addr == 7'd0) start_wr_cyc = cyc + 1;
      if (spriteram_wr_addr != 7'd0 && spriteram_wr_addr != last_addr + 7'd1) order_err++;
      last_addr = spriteram_wr_addr;
      spr[spriteram_wr_addr] = spriteram_data_in;
      wr_cnt++;
    end
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    cpu_reg_wr = 1'b1;
    cpu_reg_addr = a;
    cpu_reg_din = d;
    tick();
    cpu_reg_wr = 1'b0;
  endtask
  task automatic wait_done(input int base, input string nm);
    int b = 0;
    while (done_cnt == base && b < 400) begin
      tick();
      b++;
    end
    n_cmp++;
    if (done_cnt == base) begin
      n_err++;
      $display("FAIL %s_done: dma_done not seen within 400 clks", nm);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    vblank = 1'b0;
    cpu_reg_wr = 1'b0;
    cpu_reg_addr = 2'd0;
    cpu_reg_din = 8'h00;
    tick(3);
    n_cmp++;
    if ({cpu_reg_dout, src_addr, spriteram_wr, spriteram_wr_addr, spriteram_data_in, dma_busy, dma_done} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_outputs: dout=%h src=%h wr=%b waddr=%h wdata=%h busy=%b done=%b, want all 0",
               cpu_reg_dout, src_addr, spriteram_wr, spriteram_wr_addr, spriteram_data_in, dma_busy, dma_done);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_immediate();
    int w0, o0, d0, t0, bad;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h40);
    w0 = wr_cnt; o0 = order_err; d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    t0 = cyc;
    n_cmp++;
    if (src_addr !== 16'h4000) begin n_err++; $display("FAIL imm_src_k0: got %h want 4000", src_addr); end
    n_cmp++;
    if (cpu_reg_dout !== 8'h01) begin n_err++; $display("FAIL imm_status: got %h want 01", cpu_reg_dout); end
    wait_done(d0, "imm");
    n_cmp++;
    if (wr_cnt - w0 !== 128) begin n_err++; $display("FAIL imm_wr_count: got %0d want 128", wr_cnt - w0); end
    n_cmp++;
    if (order_err !== o0) begin n_err++; $display("FAIL imm_order: %0d out-of-order writes, want 0", order_err - o0); end
    n_cmp++;
    if (start_wr_cyc !== t0 + 2) begin n_err++; $display("FAIL imm_first_wr: got +%0d want +2", start_wr_cyc - t0); end
    n_cmp++;
    if (done_cyc !== t0 + 130) begin n_err++; $display("FAIL imm_done_time: got +%0d want +130", done_cyc - t0); end
    bad = 0;
    for (int i = 0; i < 128; i++) if (spr[i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL imm_data: %0d bad bytes, want 0", bad); end
    tick();
    n_cmp++;
    if (cpu_reg_dout !== 8'h00) begin n_err++; $display("FAIL imm_idle_status: got %h want 00", cpu_reg_dout); end
  endtask
  task automatic test_armed_edge();
    int w0, d0, t;
    vblank = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    reg_wr(2'd2, 8'h01);
    n_cmp++;
    if (cpu_reg_dout !== 8'h03) begin n_err++; $display("FAIL arm_status: got %h want 03", cpu_reg_dout); end
    n_cmp++;
    if (src_addr !== 16'h407F) begin n_err++; $display("FAIL arm_src_hold: got %h want 407f", src_addr); end
    tick(50);
    n_cmp++;
    if (wr_cnt !== w0) begin n_err++; $display("FAIL arm_early_wr: got %0d writes want 0", wr_cnt - w0); end
    vblank = 1'b1;
    t = cyc;
    tick(10);
    vblank = 1'b0;
    wait_done(d0, "arm");
    n_cmp++;
    if (start_wr_cyc !== t + 3) begin n_err++; $display("FAIL arm_first_wr: got +%0d want +3", start_wr_cyc - t); end
    n_cmp++;
    if (wr_cnt - w0 !== 128) begin n_err++; $display("FAIL arm_wr_count: got %0d want 128", wr_cnt - w0); end
  endtask
  task automatic test_armed_level();
    int w0, d0, t;
    vblank = 1'b1;
    tick(3);
    w0 = wr_cnt; d0 = done_cnt;
    reg_wr(2'd2, 8'h01);
    tick(20);
    n_cmp++;
    if (cpu_reg_dout !== 8'h03) begin n_err++; $display("FAIL lvl_status: got %h want 03", cpu_reg_dout); end
    n_cmp++;
    if (wr_cnt !== w0) begin n_err++; $display("FAIL lvl_no_wr: got %0d writes want 0", wr_cnt - w0); end
    vblank = 1'b0;
    tick(3);
    vblank = 1'b1;
    t = cyc;
    wait_done(d0, "lvl");
    vblank = 1'b0;
    n_cmp++;
    if (start_wr_cyc !== t + 3) begin n_err++; $display("FAIL lvl_first_wr: got +%0d want +3", start_wr_cyc - t); end
    n_cmp++;
    if (wr_cnt - w0 !== 128) begin n_err++; $display("FAIL lvl_wr_count: got %0d want 128", wr_cnt - w0); end
  endtask
  task automatic test_wrap();
    int w0, d0;
    reg_wr(2'd0, 8'hC0);
    reg_wr(2'd1, 8'hFF);
    w0 = wr_cnt; d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    n_cmp++;
    if (src_addr !== 16'hFFC0) begin n_err++; $display("FAIL wrap_src_k0: got %h want ffc0", src_addr); end
    tick(64);
    n_cmp++;
    if (src_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_src_k64: got %h want 0000", src_addr); end
    wait_done(d0, "wrap");
    n_cmp++;
    if ({spr[63], spr[64], spr[65]} !== 24'h3CC301) begin
      n_err++;
      $display("FAIL wrap_data: got %h %h %h want 3c c3 01", spr[63], spr[64], spr[65]);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 128) begin n_err++; $display("FAIL wrap_wr_count: got %0d want 128", wr_cnt - w0); end
  endtask
  task automatic test_write_during_copy();
    int w0, d0, bad;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h40);
    w0 = wr_cnt; d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    tick(8);
    reg_wr(2'd1, 8'h12);
    reg_wr(2'd2, 8'h03);
    wait_done(d0, "mid");
    bad = 0;
    for (int i = 0; i < 128; i++) if (spr[i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL mid_data: %0d bad bytes, want 0", bad); end
    tick(5);
    n_cmp++;
    if (wr_cnt - w0 !== 128 || done_cnt - d0 !== 1 || cpu_reg_dout !== 8'h00) begin
      n_err++;
      $display("FAIL mid_second_start: writes=%0d dones=%0d status=%h want 128 1 00", wr_cnt - w0, done_cnt - d0, cpu_reg_dout);
    end
    d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    n_cmp++;
    if (src_addr !== 16'h1200) begin n_err++; $display("FAIL mid_new_base: got %h want 1200", src_addr); end
    wait_done(d0, "mid2");
    n_cmp++;
    if ({spr[5], spr[127]} !== 16'h176D) begin n_err++; $display("FAIL mid_new_data: got %h %h want 17 6d", spr[5], spr[127]); end
  endtask
  task automatic test_reset_abort();
    int w0, d0;
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h40);
    w0 = wr_cnt; d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    tick(40);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (spriteram_wr !== 1'b0 || cpu_reg_dout !== 8'h00 || src_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_outputs: wr=%b status=%h src=%h want 0 00 0000", spriteram_wr, cpu_reg_dout, src_addr);
    end
    reset = 1'b0;
    tick(20);
    n_cmp++;
    if (wr_cnt - w0 !== 40 || last_addr !== 7'd39 || done_cnt !== d0) begin
      n_err++;
      $display("FAIL abort_writes: writes=%0d last=%0d dones=%0d want 40 39 0", wr_cnt - w0, last_addr, done_cnt - d0);
    end
    n_cmp++;
    if (spr[39] !== 8'h7D) begin n_err++; $display("FAIL abort_last_data: got %h want 7d", spr[39]); end
    d0 = done_cnt;
    reg_wr(2'd2, 8'h03);
    n_cmp++;
    if (src_addr !== 16'h0000) begin n_err++; $display("FAIL abort_base_cleared: got %h want 0000", src_addr); end
    wait_done(d0, "abort");
    n_cmp++;
    if (spr[0] !== 8'hC3) begin n_err++; $display("FAIL abort_restart_data: got %h want c3", spr[0]); end
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8);
    for (int i = 0; i < 128; i++) mem[16'h4000 + i] = 8'(i) ^ 8'h5A;
    mem[16'h0000] = 8'hC3;
    mem[16'hFFFF] = 8'h3C;
    test_reset();
    test_immediate();
    test_armed_edge();
    test_armed_level();
    test_wrap();
    test_write_during_copy();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
